// File: rtl/kernel_pio_pkg.sv
// Shared constants for the kernel bidirectional PIO: register map, edge modes, bus width.
package kernel_pio_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_MASK   = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/kernel_pio_sync_edge.sv
// Pin input synchroniser plus one history flop and per-bit edge detection.
module kernel_pio_sync_edge
    import kernel_pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_ANY
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] det
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_reg;
    logic [WIDTH-1:0]                  sync_d_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg   <= '0;
            sync_d_reg <= '0;
        end else begin
            sync_reg   <= {sync_reg[SYNC_STAGES-2:0], pin_in};
            sync_d_reg <= sync_in;
        end
    end

    assign sync_in = sync_reg[SYNC_STAGES-1];

    // Edge polarity is fixed at build time, so only the selected detector exists.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_det
            if (EDGE_TYPE == EDGE_RISE) begin : g_rise
                assign det[gi] = sync_in[gi] & ~sync_d_reg[gi];
            end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
                assign det[gi] = ~sync_in[gi] & sync_d_reg[gi];
            end else begin : g_any
                assign det[gi] = sync_in[gi] ^ sync_d_reg[gi];
            end
        end
    endgenerate

endmodule

// File: rtl/kernel_bidir_pio.sv
// Multi-bit bidirectional PIO: Avalon-MM register file, tri-state pins, edge capture, masked IRQ.
module kernel_bidir_pio
    import kernel_pio_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '0,
    parameter int               EDGE_TYPE   = EDGE_ANY,
    parameter int               SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [2:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    inout  wire  [WIDTH-1:0]  bidir_port,
    output logic              irq
);

    logic [WIDTH-1:0]  data_out_reg, data_out_next;
    logic [WIDTH-1:0]  data_dir_reg, data_dir_next;
    logic [WIDTH-1:0]  irq_mask_reg, irq_mask_next;
    logic [WIDTH-1:0]  edge_cap_reg, edge_cap_next;
    logic [DATA_W-1:0] readdata_reg, readdata_next;
    logic [WIDTH-1:0]  sync_in;
    logic [WIDTH-1:0]  det;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  edge_clr;
    logic              wr;

    assign wr    = chipselect & ~write_n;
    assign wdata = writedata[WIDTH-1:0];

    generate
        if (WIDTH < DATA_W) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[DATA_W-1:WIDTH];
        end
    endgenerate

    kernel_pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .pin_in  (bidir_port),
        .sync_in (sync_in),
        .det     (det)
    );

    always_comb begin
        data_out_next = data_out_reg;
        data_dir_next = data_dir_reg;
        irq_mask_next = irq_mask_reg;
        edge_clr      = '0;
        if (wr) begin
            case (address)
                ADDR_DATA:   data_out_next = wdata;
                ADDR_DIR:    data_dir_next = wdata;
                ADDR_MASK:   irq_mask_next = wdata;
                ADDR_EDGE:   edge_clr      = wdata;
                ADDR_OUTSET: data_out_next = data_out_reg | wdata;
                ADDR_OUTCLR: data_out_next = data_out_reg & ~wdata;
                default:     ;
            endcase
        end
        // A fresh edge overrides a simultaneous write-1-to-clear on the same bit.
        edge_cap_next = (edge_cap_reg & ~edge_clr) | det;
    end

    always_comb begin
        readdata_next = '0;
        case (address)
            ADDR_DATA: readdata_next[WIDTH-1:0] = sync_in;
            ADDR_DIR:  readdata_next[WIDTH-1:0] = data_dir_reg;
            ADDR_MASK: readdata_next[WIDTH-1:0] = irq_mask_reg;
            ADDR_EDGE: readdata_next[WIDTH-1:0] = edge_cap_reg;
            default:   readdata_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_reg <= RESET_OUT;
            data_dir_reg <= RESET_DIR;
            irq_mask_reg <= '0;
            edge_cap_reg <= '0;
            readdata_reg <= '0;
        end else begin
            data_out_reg <= data_out_next;
            data_dir_reg <= data_dir_next;
            irq_mask_reg <= irq_mask_next;
            edge_cap_reg <= edge_cap_next;
            readdata_reg <= readdata_next;
        end
    end

    assign readdata = readdata_reg;
    assign irq      = |(edge_cap_reg & irq_mask_reg);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pin
            assign bidir_port[gi] = data_dir_reg[gi] ? data_out_reg[gi] : 1'bz;
        end
    endgenerate

endmodule

// File: tb/tb_kernel_bidir_pio.sv
// Scenario bench for kernel_bidir_pio: expected read data queued at issue, compared on return.
module tb_kernel_bidir_pio;
    import kernel_pio_pkg::*;

    localparam int W = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    wire  [W-1:0]  pins;
    logic          irq;
    logic [W-1:0]  ext_drv;
    logic [W-1:0]  ext_en;

    int            total = 0;
    int            bad   = 0;
    logic [31:0]   exp_q[$];
    logic [31:0]   rd_val;
    logic [31:0]   exp_v;

    logic [2:0]    b2b_addr [6] = '{ADDR_DIR, ADDR_DATA, ADDR_MASK, ADDR_OUTSET, 3'd6, ADDR_DIR};
    logic [31:0]   b2b_exp  [6] = '{32'hFF, 32'hA5, 32'h0, 32'h0, 32'h0, 32'hFF};

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_ext
            assign pins[gi] = ext_en[gi] ? ext_drv[gi] : 1'bz;
        end
    endgenerate

    kernel_bidir_pio #(
        .WIDTH       (W),
        .RESET_OUT   (8'h00),
        .RESET_DIR   (8'h00),
        .EDGE_TYPE   (EDGE_RISE),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .bidir_port (pins),
        .irq        (irq)
    );

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        $display("WR addr=%0d data=%08h irq=%0b", a, d, irq);
    endtask

    task automatic bus_read(input logic [2:0] a);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        @(posedge clk); #1;
        rd_val = readdata; chipselect = 1'b0;
        $display("RD addr=%0d data=%08h irq=%0b", a, rd_val, irq);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk); #1;
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL reset_readdata got=%08h exp=00000000", readdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%0b exp=0", irq); end
        ext_drv = 8'h5A; #1;
        total++; if (pins !== 8'h5A) begin bad++; $display("FAIL reset_pins_undriven got=%02h exp=5a", pins); end
        ext_drv = 8'h00;
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(posedge clk);
        for (int a = 0; a < 8; a++) begin
            exp_q.push_back(32'h0);
            bus_read(3'(a));
            exp_v = exp_q.pop_front();
            total++; if (rd_val !== exp_v) begin bad++; $display("FAIL reset_reg%0d got=%08h exp=%08h", a, rd_val, exp_v); end
        end
    endtask

    task automatic test_drive();
        ext_en = 8'h00;
        bus_write(ADDR_DIR, 32'hFF);
        bus_write(ADDR_DATA, 32'hA5);
        total++; if (pins !== 8'hA5) begin bad++; $display("FAIL drive_pins got=%02h exp=a5", pins); end
        repeat (2) @(posedge clk);
        exp_q.push_back(32'hA5); bus_read(ADDR_DATA); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL drive_readback got=%08h exp=%08h", rd_val, exp_v); end
        exp_q.push_back(32'hA5); bus_read(ADDR_EDGE); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL drive_edge_capture got=%08h exp=%08h", rd_val, exp_v); end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            address = b2b_addr[k]; chipselect = 1'b1; write_n = 1'b1;
            exp_q.push_back(b2b_exp[k]);
            @(posedge clk); #1;
            rd_val = readdata; exp_v = exp_q.pop_front();
            $display("RD addr=%0d data=%08h irq=%0b", b2b_addr[k], rd_val, irq);
            total++; if (rd_val !== exp_v) begin bad++; $display("FAIL b2b_read%0d got=%08h exp=%08h", k, rd_val, exp_v); end
        end
        chipselect = 1'b0;
    endtask

    task automatic test_set_clear();
        bus_write(ADDR_OUTSET, 32'h0A);
        total++; if (pins !== 8'hAF) begin bad++; $display("FAIL outset_pins got=%02h exp=af", pins); end
        bus_write(ADDR_OUTCLR, 32'h81);
        total++; if (pins !== 8'h2E) begin bad++; $display("FAIL outclr_pins got=%02h exp=2e", pins); end
        bus_write(3'd6, 32'hFF);
        bus_write(3'd7, 32'h00);
        total++; if (pins !== 8'h2E) begin bad++; $display("FAIL unmapped_write_pins got=%02h exp=2e", pins); end
        exp_q.push_back(32'hFF); bus_read(ADDR_DIR); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL setclr_dir got=%08h exp=%08h", rd_val, exp_v); end
        exp_q.push_back(32'h0); bus_read(ADDR_OUTCLR); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL outclr_read got=%08h exp=%08h", rd_val, exp_v); end
        bus_write(ADDR_EDGE, 32'hFF);
        repeat (3) @(posedge clk);
        exp_q.push_back(32'h0); bus_read(ADDR_EDGE); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL edge_w1c_all got=%08h exp=%08h", rd_val, exp_v); end
    endtask

    task automatic test_irq();
        ext_drv = 8'h2E; ext_en = 8'hFF;
        bus_write(ADDR_DIR, 32'h00);
        ext_drv = 8'h00;
        repeat (4) @(posedge clk);
        exp_q.push_back(32'h0); bus_read(ADDR_EDGE); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL falls_ignored got=%08h exp=%08h", rd_val, exp_v); end
        bus_write(ADDR_MASK, 32'h04);
        @(negedge clk); ext_drv[2] = 1'b1;
        repeat (2) @(posedge clk); #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_early got=%0b exp=0", irq); end
        @(posedge clk); #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_latency got=%0b exp=1", irq); end
        exp_q.push_back(32'h04); bus_read(ADDR_EDGE); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL edge_pin2 got=%08h exp=%08h", rd_val, exp_v); end
        bus_write(ADDR_EDGE, 32'h04);
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_clear got=%0b exp=0", irq); end
    endtask

    task automatic test_masked_edge();
        @(negedge clk); ext_drv[3] = 1'b1;
        repeat (4) @(posedge clk); #1;
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL masked_irq got=%0b exp=0", irq); end
        exp_q.push_back(32'h08); bus_read(ADDR_EDGE); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL masked_capture got=%08h exp=%08h", rd_val, exp_v); end
        @(negedge clk); ext_drv[3] = 1'b0;
        repeat (4) @(posedge clk);
        // New rising edge reaches the capture flop on the same clock as the clear.
        @(negedge clk); ext_drv[3] = 1'b1;
        repeat (2) @(posedge clk);
        bus_write(ADDR_EDGE, 32'h08);
        exp_q.push_back(32'h08); bus_read(ADDR_EDGE); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL set_wins got=%08h exp=%08h", rd_val, exp_v); end
        bus_write(ADDR_EDGE, 32'h08);
        exp_q.push_back(32'h0); bus_read(ADDR_EDGE); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL plain_clear got=%08h exp=%08h", rd_val, exp_v); end
        bus_write(ADDR_MASK, 32'hFFFF_FF00);
        exp_q.push_back(32'h0); bus_read(ADDR_MASK); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL mask_upper_bits got=%08h exp=%08h", rd_val, exp_v); end
    endtask

    task automatic test_reset_mid();
        bus_write(ADDR_MASK, 32'h04);
        @(negedge clk); ext_drv[2] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); ext_drv[2] = 1'b1;
        repeat (4) @(posedge clk); #1;
        total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq got=%0b exp=1", irq); end
        ext_en = 8'h00;
        bus_write(ADDR_DIR, 32'hFF);
        total++; if (pins !== 8'h2E) begin bad++; $display("FAIL dir_keeps_data got=%02h exp=2e", pins); end
        exp_q.push_back(32'hFF); bus_read(ADDR_DIR); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL pre_reset_dir got=%08h exp=%08h", rd_val, exp_v); end
        @(posedge clk); #2;
        chipselect = 1'b1;
        reset_n = 1'b0; ext_drv = 8'h99; ext_en = 8'hFF; #1;
        $display("RST asserted mid-cycle readdata=%08h irq=%0b pins=%02h", readdata, irq, pins);
        total++; if (readdata !== 32'h0) begin bad++; $display("FAIL async_readdata got=%08h exp=00000000", readdata); end
        total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_irq got=%0b exp=0", irq); end
        total++; if (pins !== 8'h99) begin bad++; $display("FAIL async_pins got=%02h exp=99", pins); end
        chipselect = 1'b0;
        repeat (2) @(posedge clk);
        ext_drv = 8'h00;
        @(negedge clk); reset_n = 1'b1;
        repeat (4) @(posedge clk);
        exp_q.push_back(32'h0); bus_read(ADDR_DIR); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL post_reset_dir got=%08h exp=%08h", rd_val, exp_v); end
        exp_q.push_back(32'h0); bus_read(ADDR_EDGE); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL post_reset_edge got=%08h exp=%08h", rd_val, exp_v); end
        exp_q.push_back(32'h0); bus_read(ADDR_MASK); exp_v = exp_q.pop_front();
        total++; if (rd_val !== exp_v) begin bad++; $display("FAIL post_reset_mask got=%08h exp=%08h", rd_val, exp_v); end
        ext_en = 8'h00;
        bus_write(ADDR_DIR, 32'hFF);
        total++; if (pins !== 8'h00) begin bad++; $display("FAIL post_reset_data_out got=%02h exp=00", pins); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
        ext_drv    = 8'h00;
        ext_en     = 8'hFF;
        test_reset();
        test_drive();
        test_back_to_back();
        test_set_clear();
        test_irq();
        test_masked_edge();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
